// File: rtl/afpm_operand_deserializer_pkg.sv
// Shared constants and the state encoding for the AFPM operand deserializer slice.
package afpm_pkg;
    localparam int EXP_W = 5;
    localparam int MAN_W = 10;
    localparam int OP_W  = 1 + EXP_W + MAN_W;
    localparam int BEATS = OP_W / 8;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } state_t;

    // Bit positions inside the 4-bit class flag vector {nan, inf, sub, zero}
    localparam int ZERO = 0;
    localparam int SUB  = 1;
    localparam int INF  = 2;
    localparam int NAN  = 3;
endpackage

// File: rtl/afpm_operand_deserializer_if.sv
// Byte-serial input and unpacked-operand output bundle of the deserializer.
interface afpm_operand_deserializer_if;
    import afpm_pkg::*;

    logic             in_valid;
    logic             in_ready;
    logic [7:0]       a_byte;
    logic [7:0]       b_byte;
    logic             out_valid;
    logic             out_ready;
    logic [OP_W-1:0]  a_op;
    logic [OP_W-1:0]  b_op;
    logic             a_sign;
    logic             b_sign;
    logic [EXP_W-1:0] a_exp;
    logic [EXP_W-1:0] b_exp;
    logic [MAN_W-1:0] a_man;
    logic [MAN_W-1:0] b_man;
    logic [3:0]       a_cls;
    logic [3:0]       b_cls;

    modport master (
        output in_valid, a_byte, b_byte, out_ready,
        input  in_ready, out_valid, a_op, b_op, a_sign, b_sign,
               a_exp, b_exp, a_man, b_man, a_cls, b_cls
    );

    modport slave (
        input  in_valid, a_byte, b_byte, out_ready,
        output in_ready, out_valid, a_op, b_op, a_sign, b_sign,
               a_exp, b_exp, a_man, b_man, a_cls, b_cls
    );
endinterface

// File: rtl/afpm_operand_deserializer_fp_unpack.sv
// Combinational FP16 field split; class flags only when AFPM_CLASSIFY_EN is defined.
module afpm_fp_unpack
    import afpm_pkg::*;
(
    input  logic [OP_W-1:0]  op,
    output logic             sign,
    output logic [EXP_W-1:0] exp,
    output logic [MAN_W-1:0] man,
    output logic [3:0]       cls
);
    assign sign = op[OP_W-1];
    assign exp  = op[OP_W-2:MAN_W];
    assign man  = op[MAN_W-1:0];

`ifdef AFPM_CLASSIFY_EN
    logic exp_zero;
    logic exp_ones;
    logic man_zero;

    always_comb begin
        exp_zero  = (exp == '0);
        exp_ones  = (exp == '1);
        man_zero  = (man == '0);
        cls       = '0;
        cls[ZERO] = exp_zero &&  man_zero;
        cls[SUB]  = exp_zero && !man_zero;
        cls[INF]  = exp_ones &&  man_zero;
        cls[NAN]  = exp_ones && !man_zero;
    end
`else
    // Without classification the core treats every operand as a normal number.
    assign cls = '0;
`endif
endmodule

// File: rtl/afpm_operand_deserializer.sv
// Byte-serial FP16 operand pair assembler with registered valid/ready output.
// Optional class flags are enabled by defining AFPM_CLASSIFY_EN.
module afpm_operand_deserializer
    import afpm_pkg::*;
(
    input logic                        clk,
    input logic                        rst,
    afpm_operand_deserializer_if.slave bus
);
    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [OP_W-1:0]  a_asm;
    logic [OP_W-1:0]  b_asm;
    logic [OP_W-1:0]  a_op_q;
    logic [OP_W-1:0]  b_op_q;
    logic [OP_W-1:0]  a_nxt;
    logic [OP_W-1:0]  b_nxt;
    logic             xfer;
    logic             last;

    // In HOLD the ready simply mirrors the consumer so consume and the next byte 0 share a cycle.
    assign bus.in_ready  = (state == COLLECT) || bus.out_ready;
    assign bus.out_valid = (state == HOLD);
    assign xfer          = bus.in_valid && bus.in_ready;
    assign last          = (cnt == CNT_W'(BEATS - 1));

    always_comb begin
        a_nxt = a_asm;
        b_nxt = b_asm;
        for (int k = 0; k < BEATS; k++) begin
            if (cnt == CNT_W'(k)) begin
                a_nxt[8*k +: 8] = bus.a_byte;
                b_nxt[8*k +: 8] = bus.b_byte;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= COLLECT;
            cnt    <= '0;
            a_asm  <= '0;
            b_asm  <= '0;
            a_op_q <= '0;
            b_op_q <= '0;
        end else if (xfer) begin
            a_asm <= a_nxt;
            b_asm <= b_nxt;
            if (last) begin
                cnt    <= '0;
                state  <= HOLD;
                a_op_q <= a_nxt;
                b_op_q <= b_nxt;
            end else begin
                cnt   <= cnt + CNT_W'(1);
                state <= COLLECT;
            end
        end else if (state == HOLD && bus.out_ready) begin
            state <= COLLECT;
        end
    end

    assign bus.a_op = a_op_q;
    assign bus.b_op = b_op_q;

    afpm_fp_unpack u_unpack_a (
        .op   (a_op_q),
        .sign (bus.a_sign),
        .exp  (bus.a_exp),
        .man  (bus.a_man),
        .cls  (bus.a_cls)
    );

    afpm_fp_unpack u_unpack_b (
        .op   (b_op_q),
        .sign (bus.b_sign),
        .exp  (bus.b_exp),
        .man  (bus.b_man),
        .cls  (bus.b_cls)
    );
endmodule

// File: tb/tb_afpm_operand_deserializer.sv
// Directed plus randomized bench for afpm_operand_deserializer against an arithmetic FP16 model.
module tb_afpm_operand_deserializer;
    import afpm_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   total  = 0;
    int   passed = 0;

    afpm_operand_deserializer_if bus ();

    afpm_operand_deserializer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: fields derived arithmetically from the 16-bit value.
    function automatic logic [31:0] m_sign(input int op);
        return op / (2 ** (OP_W - 1));
    endfunction
    function automatic logic [31:0] m_exp(input int op);
        return (op / (2 ** MAN_W)) % (2 ** EXP_W);
    endfunction
    function automatic logic [31:0] m_man(input int op);
        return op % (2 ** MAN_W);
    endfunction
    function automatic logic [31:0] m_cls(input int op);
`ifdef AFPM_CLASSIFY_EN
        int e = m_exp(op);
        int m = m_man(op);
        if (e == 2 ** EXP_W - 1) return (m != 0) ? 8 : 4;
        if (e == 0)              return (m != 0) ? 2 : 1;
        return 0;
`else
        return 0;
`endif
    endfunction

    task automatic check_pair(input string tag, input int a, input int b);
        check({tag, "_vld"},  bus.out_valid, 1);
        check({tag, "_aop"},  bus.a_op, a);
        check({tag, "_bop"},  bus.b_op, b);
        check({tag, "_asg"},  bus.a_sign, m_sign(a));
        check({tag, "_bsg"},  bus.b_sign, m_sign(b));
        check({tag, "_aexp"}, bus.a_exp, m_exp(a));
        check({tag, "_bexp"}, bus.b_exp, m_exp(b));
        check({tag, "_aman"}, bus.a_man, m_man(a));
        check({tag, "_bman"}, bus.b_man, m_man(b));
        check({tag, "_acls"}, bus.a_cls, m_cls(a));
        check({tag, "_bcls"}, bus.b_cls, m_cls(b));
    endtask

    task automatic send_beat(input logic [7:0] a, input logic [7:0] b);
        int n = 0;
        bus.in_valid = 1'b1;
        bus.a_byte   = a;
        bus.b_byte   = b;
        #1;
        while (!bus.in_ready && n < 50) begin
            step();
            n++;
        end
        check("beat_wait", (n < 50), 1);
        step();
        bus.in_valid = 1'b0;
    endtask

    // Sends an operand pair least-significant byte first.
    task automatic send_pair(input int a, input int b);
        for (int k = 0; k < BEATS; k++)
            send_beat(8'((a >> (8 * k)) & 255), 8'((b >> (8 * k)) & 255));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        int ra, rb, wait_n;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.a_byte    = '0;
        bus.b_byte    = '0;
        bus.out_ready = 1'b1;
        step();
        step();
        rst = 1'b0;

        check("rst_vld",  bus.out_valid, 0);
        check("rst_rdy",  bus.in_ready, 1);
        check("rst_aop",  bus.a_op, 0);
        check("rst_bop",  bus.b_op, 0);
        check("rst_acls", bus.a_cls, 0);

        // Nominal pair: 1.5 x 3.0
        send_pair(16'h3E00, 16'h4200);
        check_pair("nom", 16'h3E00, 16'h4200);
        check("nom_aexp_lit", bus.a_exp, 5'h0F);
        check("nom_bexp_lit", bus.b_exp, 5'h10);
        check("nom_man_lit", bus.a_man, 10'h200);
        step();
        check("nom_drop", bus.out_valid, 0);

        // Backpressure with a beat offered during the stall
        bus.out_ready = 1'b0;
        send_pair(16'h3E00, 16'h4200);
        bus.in_valid = 1'b1;
        bus.a_byte   = 8'h00;
        bus.b_byte   = 8'h00;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("bp_vld", bus.out_valid, 1);
            check("bp_aop", bus.a_op, 16'h3E00);
            check("bp_rdy", bus.in_ready, 0);
            step();
        end
        bus.out_ready = 1'b1;
        #1;
        check("bp_rdy_pass", bus.in_ready, 1);
        step();
        bus.in_valid = 1'b0;
        check("bp_consume", bus.out_valid, 0);
        send_beat(8'h3C, 8'h3C);
        check_pair("bp_next", 16'h3C00, 16'h3C00);
        step();

        // Back-to-back streaming
        bus.in_valid = 1'b1;
        bus.a_byte = 8'h00; bus.b_byte = 8'h00; step();
        check("st_b0", bus.out_valid, 0);
        bus.a_byte = 8'h3E; bus.b_byte = 8'h42; step();
        check_pair("st_p1", 16'h3E00, 16'h4200);
        bus.a_byte = 8'h00; bus.b_byte = 8'h00; step();
        check("st_mid", bus.out_valid, 0);
        bus.a_byte = 8'hC0; bus.b_byte = 8'h3C; step();
        check_pair("st_p2", 16'hC000, 16'h3C00);
        bus.in_valid = 1'b0;
        step();
        check("st_end", bus.out_valid, 0);

        // Special values
        send_pair(16'h0000, 16'h0001);
        check_pair("sp_zs", 16'h0000, 16'h0001);
        step();
        send_pair(16'h7C00, 16'h7E00);
        check_pair("sp_in", 16'h7C00, 16'h7E00);
        step();

        // Randomized pairs with random hold time
        for (int i = 0; i < 24; i++) begin
            ra = int'($urandom_range(0, 65535));
            rb = int'($urandom_range(0, 65535));
            if (i % 4 == 1) ra = ra & 16'h83FF;
            if (i % 4 == 2) rb = rb | 16'h7C00;
            bus.out_ready = 1'b0;
            send_pair(ra, rb);
            check_pair("rnd", ra, rb);
            wait_n = int'($urandom_range(0, 3));
            for (int j = 0; j < wait_n; j++) begin
                step();
                check("rnd_hold_aop", bus.a_op, ra);
                check("rnd_hold_vld", bus.out_valid, 1);
            end
            bus.out_ready = 1'b1;
            step();
            check("rnd_drop", bus.out_valid, 0);
        end

        // Reset mid-frame discards the partial pair
        send_beat(8'h11, 8'h22);
        do_reset();
        check("rmf_vld", bus.out_valid, 0);
        check("rmf_rdy", bus.in_ready, 1);
        send_pair(16'h3E00, 16'h4200);
        check_pair("rmf", 16'h3E00, 16'h4200);
        step();

        // Reset while holding a pair
        bus.out_ready = 1'b0;
        send_pair(16'h1234, 16'h5678);
        check("rh_vld_pre", bus.out_valid, 1);
        do_reset();
        check("rh_vld", bus.out_valid, 0);
        check("rh_rdy", bus.in_ready, 1);
        check("rh_aop", bus.a_op, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
